// File: rtl/btb_pkg.sv
// btb_pkg: shared direction-counter encoding and helpers for the branch target buffer
package btb_pkg;
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} ctr_e;
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    return taken ? (ctr == ST ? ctr : ctr + 2'd1) : (ctr == SNT ? ctr : ctr - 2'd1);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btb_assoc_predictor_if.sv
// btb_assoc_predictor_if: query/response/update/flush bundle between fetch, resolve and the BTB
//   master: fetch/resolve side drives query_*, upd_*, flush and receives resp_*
//   slave : the BTB
interface btb_assoc_predictor_if #(parameter int ADDR_W = 32);
  logic              flush;
  logic              query_valid;
  logic [ADDR_W-1:0] query_pc;
  logic              resp_valid;
  logic              resp_hit;
  logic              resp_taken;
  logic [ADDR_W-1:0] resp_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  modport master (output flush, query_valid, query_pc, upd_valid, upd_pc, upd_taken, upd_target,
                  input  resp_valid, resp_hit, resp_taken, resp_target);
  modport slave  (input  flush, query_valid, query_pc, upd_valid, upd_pc, upd_taken, upd_target,
                  output resp_valid, resp_hit, resp_taken, resp_target);
endinterface

// File: rtl/btb_victim_sel.sv
// btb_victim_sel: picks the allocation victim (lowest invalid entry, else oldest with lowest-index tie-break)
//   i_valid       per-entry valid bits
//   i_age         per-entry age counters
//   o_idx         victim index
//   o_any_invalid at least one entry is free
module btb_victim_sel #(
  parameter int ENTRIES = 32,
  parameter int AGE_W   = 7,
  parameter int IDX_W   = 5
) (
  input  logic [ENTRIES-1:0] i_valid,
  input  logic [AGE_W-1:0]   i_age [ENTRIES],
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any_invalid
);
  logic [IDX_W-1:0] w_inv_idx, w_old_idx;
  logic [AGE_W-1:0] w_max;
  always_comb begin
    w_inv_idx = '0;
    w_old_idx = '0;
    w_max     = i_age[0];
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!i_valid[i]) w_inv_idx = IDX_W'(i);
    // strict '>' keeps the earlier index on equal ages
    for (int i = 1; i < ENTRIES; i++)
      if (i_age[i] > w_max) begin
        w_max     = i_age[i];
        w_old_idx = IDX_W'(i);
      end
  end
  assign o_any_invalid = ~&i_valid;
  assign o_idx         = o_any_invalid ? w_inv_idx : w_old_idx;
endmodule

// File: rtl/btb_assoc_predictor.sv
// btb_assoc_predictor: fully-associative BTB with 2-bit direction counters and age-based LRU
//   clk     rising-edge clock
//   clear_n asynchronous active-low reset
//   bus     slave side of btb_assoc_predictor_if (query/resp, update, flush)
module btb_assoc_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES    = 32,
  parameter int ADDR_W     = 32,
  parameter int AGE_W      = 7,
  parameter int INST_BYTES = 4
) (
  input logic                  clk,
  input logic                  clear_n,
  btb_assoc_predictor_if.slave bus
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [AGE_W-1:0]   r_age    [ENTRIES];
  logic [ADDR_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic               r_resp_valid, r_resp_hit, r_resp_taken;
  logic [ADDR_W-1:0]  r_resp_target;
  logic [ENTRIES-1:0] w_q_hit, w_u_hit, w_vic_oh, w_touch;
  logic [IDX_W-1:0]   w_q_idx, w_vic;
  logic               w_q_any, w_u_any, w_q_taken, w_alloc, w_active, w_unused_any_inv;
  btb_victim_sel #(.ENTRIES(ENTRIES), .AGE_W(AGE_W), .IDX_W(IDX_W)) u_vic (
    .i_valid      (r_valid),
    .i_age        (r_age),
    .o_idx        (w_vic),
    .o_any_invalid(w_unused_any_inv)
  );
  always_comb begin
    w_q_hit  = '0;
    w_u_hit  = '0;
    w_q_idx  = '0;
    w_vic_oh = '0;
    w_vic_oh[w_vic] = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      w_q_hit[i] = r_valid[i] && r_tag[i] == bus.query_pc;
      w_u_hit[i] = r_valid[i] && r_tag[i] == bus.upd_pc;
      if (w_q_hit[i]) w_q_idx = IDX_W'(i);
    end
  end
  assign w_q_any   = |w_q_hit;
  assign w_u_any   = |w_u_hit;
  assign w_q_taken = w_q_any && r_ctr[w_q_idx][1];
  assign w_active  = bus.query_valid | bus.upd_valid;
  // allocation only on a taken miss, and a flush cancels it outright
  assign w_alloc   = bus.upd_valid & bus.upd_taken & ~w_u_any & ~bus.flush;
  assign w_touch   = ({ENTRIES{bus.query_valid}} & w_q_hit) | ({ENTRIES{bus.upd_valid}} & w_u_hit)
                   | ({ENTRIES{w_alloc}} & w_vic_oh);
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_valid       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_resp_taken  <= 1'b0;
      r_resp_target <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= SNT;
        r_age[i] <= '0;
      end
    end else begin
      r_resp_valid <= bus.query_valid;
      if (bus.query_valid) begin
        r_resp_hit    <= w_q_any;
        r_resp_taken  <= w_q_taken;
        r_resp_target <= w_q_taken ? r_target[w_q_idx] : bus.query_pc + ADDR_W'(INST_BYTES);
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.flush) begin
          r_valid[i] <= 1'b0;
          r_age[i]   <= '0;
        end else begin
          if (w_alloc && w_vic_oh[i]) begin
            r_valid[i] <= 1'b1;
            r_ctr[i]   <= WT;
          end else if (bus.upd_valid && w_u_hit[i])
            r_ctr[i] <= ctr_next(r_ctr[i], bus.upd_taken);
          if (w_touch[i])
            r_age[i] <= '0;
          else if (r_valid[i] && w_active && r_age[i] != AGE_MAX)
            r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end
  // tag/target payload needs no reset: valid bits gate every use
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++)
      if (w_alloc && w_vic_oh[i]) begin
        r_tag[i]    <= bus.upd_pc;
        r_target[i] <= bus.upd_target;
      end else if (!bus.flush && bus.upd_valid && bus.upd_taken && w_u_hit[i])
        r_target[i] <= bus.upd_target;
  end
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_hit    = r_resp_hit;
  assign bus.resp_taken  = r_resp_taken;
  assign bus.resp_target = r_resp_target;
endmodule

// File: tb/tb_btb_assoc_predictor.sv
// tb_btb_assoc_predictor: directed stimulus against a rule-level BTB model with per-cycle comparison
module tb_btb_assoc_predictor;
  localparam int N = 32;
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int checks = 0;
  int errors = 0;
  btb_assoc_predictor_if #(.ADDR_W(32)) bus ();
  btb_assoc_predictor #(.ENTRIES(N), .ADDR_W(32), .AGE_W(7), .INST_BYTES(4)) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  int          m_valid [N];
  int          m_ctr   [N];
  int          m_age   [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  logic        e_valid = 1'b0, e_hit = 1'b0, e_taken = 1'b0;
  logic [31:0] e_target = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int find(input logic [31:0] pc);
    for (int i = 0; i < N; i++)
      if (m_valid[i] != 0 && m_tag[i] == pc) return i;
    return -1;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
      m_age[i]   = 0;
    end
    e_valid = 0; e_hit = 0; e_taken = 0; e_target = '0;
  endtask
  task automatic step(input bit qv, input logic [31:0] qpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit fl);
    bit          touched [N];
    int          qi, ui, v;
    logic        nh, nt;
    logic [31:0] ntg;
    @(negedge clk);
    bus.query_valid = qv; bus.query_pc = qpc;
    bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut; bus.upd_target = utgt;
    bus.flush = fl;
    for (int i = 0; i < N; i++) touched[i] = 0;
    qi = find(qpc);
    nh = e_hit; nt = e_taken; ntg = e_target;
    if (qv) begin
      nh  = qi >= 0;
      nt  = nh && m_ctr[qi] >= 2;
      ntg = nt ? m_tgt[qi] : qpc + 32'd4;
    end
    if (fl) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0;
        m_age[i]   = 0;
      end
    end else begin
      if (qv && qi >= 0) touched[qi] = 1;
      if (uv) begin
        ui = find(upc);
        if (ui >= 0) begin
          m_ctr[ui] = ut ? (m_ctr[ui] < 3 ? m_ctr[ui] + 1 : 3) : (m_ctr[ui] > 0 ? m_ctr[ui] - 1 : 0);
          if (ut) m_tgt[ui] = utgt;
          touched[ui] = 1;
        end else if (ut) begin
          v = -1;
          for (int i = 0; i < N; i++) if (v < 0 && m_valid[i] == 0) v = i;
          if (v < 0) begin
            v = 0;
            for (int i = 1; i < N; i++) if (m_age[i] > m_age[v]) v = i;
          end
          m_valid[v] = 1; m_tag[v] = upc; m_tgt[v] = utgt; m_ctr[v] = 2;
          touched[v] = 1;
        end
      end
      for (int i = 0; i < N; i++)
        if (touched[i]) m_age[i] = 0;
        else if (m_valid[i] != 0 && (qv || uv)) m_age[i] = m_age[i] < 127 ? m_age[i] + 1 : 127;
    end
    @(posedge clk);
    e_valid = qv; e_hit = nh; e_taken = nt; e_target = ntg;
    #1;
  endtask
  task automatic q(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0);
  endtask
  task automatic u(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    step(0, 0, 1, pc, t, tgt, 0);
  endtask
  task automatic exp_resp(input string name, input logic h, input logic t, input logic [31:0] tg);
    chk({name, "_valid"}, bus.resp_valid, 1);
    chk({name, "_hit"}, bus.resp_hit, h);
    chk({name, "_taken"}, bus.resp_taken, t);
    chk({name, "_target"}, bus.resp_target, tg);
  endtask
  always @(negedge clk) begin
    chk("cmp_valid", bus.resp_valid, e_valid);
    chk("cmp_hit", bus.resp_hit, e_hit);
    chk("cmp_taken", bus.resp_taken, e_taken);
    chk("cmp_target", bus.resp_target, e_target);
  end
  initial begin
    bus.query_valid = 0; bus.query_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0;
    bus.upd_taken = 0; bus.upd_target = 0; bus.flush = 0;
    model_reset();
    #12;
    chk("reset_valid", bus.resp_valid, 0);
    chk("reset_hit", bus.resp_hit, 0);
    chk("reset_taken", bus.resp_taken, 0);
    chk("reset_target", bus.resp_target, 0);
    @(negedge clk);
    clear_n = 1'b1;
    q(32'h100);
    exp_resp("cold_miss", 0, 0, 32'h104);
    u(32'h100, 1, 32'h400);
    chk("upd_only_valid", bus.resp_valid, 0);
    q(32'h100);
    exp_resp("alloc_hit", 1, 1, 32'h400);
    u(32'h100, 0, 32'h0);
    q(32'h100);
    exp_resp("weak_nt", 1, 0, 32'h104);
    for (int i = 0; i < 4; i++) u(32'h200, 1, 32'h800);
    chk("model_ctr_sat3", m_ctr[find(32'h200)], 3);
    q(32'h200);
    exp_resp("ctr3", 1, 1, 32'h800);
    u(32'h200, 0, 0);
    q(32'h200);
    exp_resp("ctr2", 1, 1, 32'h800);
    u(32'h200, 0, 0);
    q(32'h200);
    exp_resp("ctr1", 1, 0, 32'h204);
    u(32'h200, 0, 0);
    q(32'h200);
    exp_resp("ctr0", 1, 0, 32'h204);
    u(32'h200, 0, 0);
    chk("model_ctr_sat0", m_ctr[find(32'h200)], 0);
    q(32'h200);
    exp_resp("ctr0_hold", 1, 0, 32'h204);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) u(32'h1000 + 32'(4 * i), 1, 32'h2000 + 32'(4 * i));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) if (i != 5) q(32'h1000 + 32'(4 * i));
    u(32'h9000, 1, 32'h9400);
    chk("model_victim", find(32'h9000), 5);
    q(32'h1014);
    exp_resp("evicted", 0, 0, 32'h1018);
    q(32'h9000);
    exp_resp("new_entry", 1, 1, 32'h9400);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h300, 1, 32'h300, 1, 32'h600, 0);
    exp_resp("rbw", 0, 0, 32'h304);
    q(32'h300);
    exp_resp("after_rbw", 1, 1, 32'h600);
    u(32'h500, 1, 32'h510);
    u(32'h504, 1, 32'h514);
    u(32'h508, 1, 32'h518);
    step(0, 0, 1, 32'h700, 1, 32'h7f0, 1);
    q(32'h500);
    exp_resp("flush_500", 0, 0, 32'h504);
    q(32'h504);
    exp_resp("flush_504", 0, 0, 32'h508);
    q(32'h508);
    exp_resp("flush_508", 0, 0, 32'h50c);
    q(32'h700);
    exp_resp("flush_700", 0, 0, 32'h704);
    u(32'h500, 1, 32'h510);
    q(32'h100);
    chk("pre_drop_valid", bus.resp_valid, 1);
    #1;
    clear_n = 1'b0;
    model_reset();
    #1;
    chk("drop_valid", bus.resp_valid, 0);
    chk("drop_hit", bus.resp_hit, 0);
    @(negedge clk);
    clear_n = 1'b1;
    bus.query_valid = 0; bus.upd_valid = 0; bus.flush = 0;
    q(32'h500);
    exp_resp("post_reset", 0, 0, 32'h504);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_assoc_predictor.md
Name: btb_assoc_predictor

Overview:
- Parametrised fully-associative branch target buffer with per-entry 2-bit saturating direction counters and age-based LRU replacement.
- Sits in the IF stage: queried with the fetch PC each cycle, and updated from the EX/branch-resolve stage with the actual outcome.
- Successor to the fixed 32-entry associative predictor. Adds:
  - depth and width parameters
  - registered 1-cycle lookup with a valid strobe
  - a valid bit per entry
  - a flush input
  - defined same-cycle query/update ordering
  - deterministic victim selection

Parameters:
- ENTRIES, 32, number of entries; power of 2, 2..256.
- ADDR_W, 32, PC/target width.
- AGE_W, 7, width of each saturating age counter.
- INST_BYTES, 4, fall-through increment for a not-taken prediction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clear_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous invalidate of all entries.
- query_valid  in  1  lookup request this cycle.
- query_pc  in  ADDR_W  PC to predict.
- resp_valid  out  1  response strobe, one cycle after query_valid.
- resp_hit  out  1  query_pc matched a valid entry.
- resp_taken  out  1  predicted taken (hit and counter >= 2).
- resp_target  out  ADDR_W  stored target if resp_taken, else query_pc+INST_BYTES.
- upd_valid  in  1  resolved-branch update this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual branch target.

Behaviour:
- Reset: clk and clear_n as named. Reset is asynchronous, active-low. While clear_n=0:
  - all valid bits, counters and ages are 0
  - resp_valid, resp_hit and resp_taken are 0; resp_target is 0
  - tag and target storage is not reset.
- Entry state: valid, tag[ADDR_W], target[ADDR_W], ctr[2], age[AGE_W].
- Counter encoding: 0 = strong-not-taken, 1 = weak-not-taken, 2 = weak-taken, 3 = strong-taken.
- Lookup (1-cycle latency):
  - Match is valid && tag==query_pc. At most one entry can match, because allocation only occurs on a miss.
  - Next edge: resp_valid<=query_valid, resp_hit<=match, resp_taken<=match && ctr[1], resp_target per the port rule (adds wrap modulo 2^ADDR_W).
  - With query_valid=0: resp_valid<=0; the other resp_* outputs hold their previous values.
- Update on an update hit (matching valid entry):
  - upd_taken=1: ctr saturating +1 and target<=upd_target.
  - upd_taken=0: ctr saturating -1; target unchanged.
  - The entry's age is set to 0.
- Update on an update miss:
  - upd_taken=0: ignored.
  - upd_taken=1: allocate a victim with valid=1, tag=upd_pc, target=upd_target, ctr=2, age=0.
  - Victim selection: the lowest-index invalid entry; if all entries are valid, the entry with maximum age, lowest index on a tie.
- Ageing, per edge:
  - Any entry touched by a query hit or by an update (hit or allocate) gets age<=0.
  - Every other valid entry gets age saturating +1, but only if query_valid or upd_valid is active.
  - Ages saturate at 2^AGE_W-1.
- Same-cycle query and update:
  - The query observes pre-update state (read-before-write), including when query_pc==upd_pc.
  - Both touched entries get age 0.
- Flush:
  - Clears every valid bit and age at the next edge.
  - Overrides a same-cycle upd_valid; nothing is allocated.
  - A same-cycle query still responds from pre-flush state.
- Reset mid-operation: an in-flight response is dropped (resp_valid=0). No partial update survives.

Decomposition:
- Package btb_pkg:
  - counter encodings SNT/WNT/WT/ST
  - function ctr_next(ctr, taken) (saturating)
  - function clog2-based IDX_W = $clog2(ENTRIES).
- One sub-module, btb_victim_sel: combinational scan that returns the victim index (first invalid, else oldest with lowest-index tie-break) and an any_invalid flag.
- The top level holds storage, match logic, age update and the response register.

Test Plan:
- Reset, then query 0x100 -> next cycle resp_valid=1, resp_hit=0, resp_taken=0, resp_target=0x104.
- Update pc=0x100, taken, target=0x400. Then query 0x100 -> hit=1, taken=1 (ctr=2), target=0x400. Then one not-taken update and a query -> hit=1, taken=0, target=0x104.
- Apply four taken updates, then three not-taken updates to 0x200 (target 0x800):
  - ctr saturates at 3 after the taken updates
  - after the not-taken updates, ctr steps 2, 1, 0
  - a query then gives taken=0
  - a further not-taken update keeps ctr=0.
- Fill all ENTRIES with taken updates to 0x1000+4i. Query every entry except i=5 repeatedly. A new taken update to 0x9000 evicts entry 5: query 0x1014 misses and query 0x9000 hits.
- Same cycle: query 0x300 and taken update 0x300 (target 0x600) on an empty BTB -> that response is hit=0. A query the next cycle -> hit=1, target=0x600.
- Populate 3 entries, then assert flush together with a taken update to 0x700 -> queries to all 4 PCs miss afterwards. Also drop clear_n while resp_valid=1 -> resp_valid goes 0 immediately.
